// File: rtl/ddc_avg_pkg.sv
// Shared definitions for the DDC block averager: FSM encoding, default block-size limit
// and accumulator sizing.
package ddc_avg_pkg;

    localparam int MAX_LOG2N_DEF = 10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // A sum of 2^max_log2n samples needs max_log2n extra bits to never wrap.
    function automatic int acc_width(input int data_w, input int max_log2n);
        return data_w + max_log2n;
    endfunction

endpackage

// File: rtl/ddc_avg_round.sv
// Round-half-up divide by 2^k of a block sum, truncated to the output width.
// The sum is widened by one bit so adding the rounding term can never wrap.
module ddc_avg_round #(
    parameter int IN_W   = 35,
    parameter int OUT_W  = 25,
    parameter int K_W    = 4,
    parameter bit SIGNED = 1'b1
) (
    input  logic [IN_W-1:0]  sum,
    input  logic [K_W-1:0]   k,
    output logic [OUT_W-1:0] res
);

    localparam logic [IN_W:0] ONE = 1;

    logic [IN_W:0] sum_ext;
    logic [IN_W:0] rnd;
    logic [IN_W:0] biased;

    assign rnd    = (k == '0) ? '0 : (ONE << (k - 1'b1));
    assign biased = sum_ext + rnd;

    generate
        if (SIGNED) begin : g_signed
            assign sum_ext = {sum[IN_W-1], sum};
            assign res     = OUT_W'($signed(biased) >>> k);
        end else begin : g_unsigned
            assign sum_ext = {1'b0, sum};
            assign res     = OUT_W'(biased >> k);
        end
    endgenerate

endmodule

// File: rtl/ddc_avg.sv
// Block averager behind the DDC: sums 2^k valid I/Q/amplitude samples and presents the
// rounded mean through a valid/ready output register with a sticky overrun flag.
module ddc_avg
    import ddc_avg_pkg::*;
#(
    parameter int DATA_WIDTH = 25,
    parameter int MAX_LOG2N  = MAX_LOG2N_DEF,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [3:0]            log2n_i,
    input  logic                  val_i,
    input  logic [DATA_WIDTH-1:0] i_i,
    input  logic [DATA_WIDTH-1:0] q_i,
    input  logic [DATA_WIDTH-1:0] amp_i,
    output logic [DATA_WIDTH-1:0] i_o,
    output logic [DATA_WIDTH-1:0] q_o,
    output logic [DATA_WIDTH-1:0] amp_o,
    output logic                  val_o,
    input  logic                  rdy_i,
    output logic                  overrun_o,
    output logic [CNT_WIDTH-1:0]  blk_cnt_o
);

    localparam int ACC_W = acc_width(DATA_WIDTH, MAX_LOG2N);
    localparam int CW    = MAX_LOG2N + 1;
    localparam int NCH   = 3;

    logic [1:0]            state_reg, state_next;
    logic [CW-1:0]         cnt_reg;
    logic [CW-1:0]         cnt_inc;
    logic [CW-1:0]         blk_len;
    logic [3:0]            k_reg, k_in, k_eff, sum_k_reg;
    logic                  running, active, first, block_end, offered;
    logic                  load, drop;
    logic [DATA_WIDTH-1:0] din [NCH];
    logic [DATA_WIDTH-1:0] res [NCH];

    assign din[0] = i_i;
    assign din[1] = q_i;
    assign din[2] = amp_i;

    assign running   = en_i && (state_reg != ST_IDLE);
    assign active    = running && val_i;
    assign first     = (cnt_reg == '0);
    assign k_in      = (log2n_i > 4'(MAX_LOG2N)) ? 4'(MAX_LOG2N) : log2n_i;
    // The block length is frozen by the first sample; later log2n_i changes are ignored.
    assign k_eff     = first ? k_in : k_reg;
    assign cnt_inc   = cnt_reg + 1'b1;
    assign blk_len   = CW'(1) << k_eff;
    assign block_end = active && (cnt_inc == blk_len);
    assign offered   = (state_reg == ST_DONE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: state_next = en_i ? ST_ACCUM : ST_IDLE;
            default: begin
                if (!en_i)          state_next = ST_IDLE;
                else if (block_end) state_next = ST_DONE;
                else                state_next = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            k_reg     <= '0;
            sum_k_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (!running)
                cnt_reg <= '0;
            else if (active)
                cnt_reg <= block_end ? '0 : cnt_inc;
            if (active && first)
                k_reg <= k_in;
            if (block_end)
                sum_k_reg <= k_eff;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [ACC_W-1:0] ext;
            logic [ACC_W-1:0] acc_reg;
            logic [ACC_W-1:0] acc_sum;
            logic [ACC_W-1:0] sum_reg;

            // Channels 0/1 are signed I/Q, channel 2 is the unsigned amplitude.
            if (gi < 2) begin : g_sx
                assign ext = {{MAX_LOG2N{din[gi][DATA_WIDTH-1]}}, din[gi]};
            end else begin : g_zx
                assign ext = {{MAX_LOG2N{1'b0}}, din[gi]};
            end

            assign acc_sum = acc_reg + ext;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    acc_reg <= '0;
                    sum_reg <= '0;
                end else begin
                    if (!running)
                        acc_reg <= '0;
                    else if (active)
                        acc_reg <= block_end ? '0 : acc_sum;
                    if (block_end)
                        sum_reg <= acc_sum;
                end
            end

            ddc_avg_round #(
                .IN_W   (ACC_W),
                .OUT_W  (DATA_WIDTH),
                .K_W    (4),
                .SIGNED (gi < 2)
            ) u_round (
                .sum (sum_reg),
                .k   (sum_k_reg),
                .res (res[gi])
            );
        end
    endgenerate

    assign load = offered && (!val_o || rdy_i);
    assign drop = offered && val_o && !rdy_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            i_o       <= '0;
            q_o       <= '0;
            amp_o     <= '0;
            val_o     <= 1'b0;
            overrun_o <= 1'b0;
            blk_cnt_o <= '0;
        end else begin
            if (load) begin
                i_o       <= res[0];
                q_o       <= res[1];
                amp_o     <= res[2];
                val_o     <= 1'b1;
                blk_cnt_o <= blk_cnt_o + 1'b1;
            end else if (val_o && rdy_i) begin
                val_o <= 1'b0;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)
                overrun_o <= 1'b1;
            else if (clr_i)
                overrun_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ddc_avg.sv
// Scoreboard bench for ddc_avg: expected means are queued as blocks are driven and
// compared whenever the produced-block counter advances.
module tb_ddc_avg;

    localparam int DW = 25;

    logic          clk, rst_n, en, clr, val, rdy;
    logic [3:0]    log2n;
    logic [DW-1:0] i_in, q_in, a_in;
    logic [DW-1:0] i_out, q_out, a_out;
    logic          val_out, overrun;
    logic [15:0]   blk_cnt;

    typedef struct {
        logic [DW-1:0] i;
        logic [DW-1:0] q;
        logic [DW-1:0] a;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    ddc_avg dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .en_i      (en),
        .clr_i     (clr),
        .log2n_i   (log2n),
        .val_i     (val),
        .i_i       (i_in),
        .q_i       (q_in),
        .amp_i     (a_in),
        .i_o       (i_out),
        .q_o       (q_out),
        .amp_o     (a_out),
        .val_o     (val_out),
        .rdy_i     (rdy),
        .overrun_o (overrun),
        .blk_cnt_o (blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
        end
    endtask

    function automatic longint rmean(input longint s, input int k);
        if (k == 0) return s;
        return (s + (longint'(1) << (k - 1))) >>> k;
    endfunction

    task automatic push_exp(input longint si, input longint sq, input longint sa, input int k);
        exp_t e;
        e.i = DW'(rmean(si, k));
        e.q = DW'(rmean(sq, k));
        e.a = DW'(rmean(sa, k));
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input longint i, input longint q, input longint a);
        val  = 1'b1;
        i_in = DW'(i);
        q_in = DW'(q);
        a_in = DW'(a);
        @(posedge clk);
        #1;
        val = 1'b0;
    endtask

    // Monitor: every increment of the block counter is one loaded result.
    initial begin
        logic [15:0] last_cnt;
        exp_t e;
        last_cnt = '0;
        forever begin
            @(posedge clk);
            #1;
            if (blk_cnt == 16'(last_cnt + 1'b1)) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("sb_i", i_out, e.i);
                    check("sb_q", q_out, e.q);
                    check("sb_amp", a_out, e.a);
                    $display("result blk=%0d i=%0d q=%0d amp=%0d", blk_cnt,
                             $signed(i_out), $signed(q_out), a_out);
                end
            end
            last_cnt = blk_cnt;
        end
    end

    initial begin
        int amp_t1[4] = '{5, 5, 5, 6};
        longint si, sq, sa;

        rst_n = 1'b0; en = 1'b0; clr = 1'b0; val = 1'b0; rdy = 1'b1;
        log2n = 4'd2; i_in = '0; q_in = '0; a_in = '0;
        tick(2);
        check("rst_i", i_out, 0);
        check("rst_q", q_out, 0);
        check("rst_amp", a_out, 0);
        check("rst_val", val_out, 0);
        check("rst_ovr", overrun, 0);
        check("rst_cnt", blk_cnt, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        en = 1'b1;
        tick(1);

        // k=2 basic mean and latency
        push_exp(10, -10, 21, 2);
        for (int n = 0; n < 4; n++) send(n + 1, -(n + 1), amp_t1[n]);
        check("t1_val_early", val_out, 0);
        tick(1);
        check("t1_val", val_out, 1);
        check("t1_cnt", blk_cnt, 1);

        // k=0 streaming ramp
        log2n = 4'd0;
        for (int n = 0; n < 10; n++) begin
            push_exp(n, -n, n, 0);
            send(n, -n, n);
            if (n >= 1) begin
                check("t2_val", val_out, 1);
                check("t2_ramp", i_out, n - 1);
            end
        end
        tick(3);
        check("t2_cnt", blk_cnt, 11);

        // k=3 full-scale values
        log2n = 4'd3;
        push_exp(8 * ((1 << 24) - 1), -8 * (1 << 24), 8 * ((1 << 25) - 1), 3);
        for (int n = 0; n < 8; n++) send((1 << 24) - 1, -(1 << 24), (1 << 25) - 1);
        tick(3);
        check("t3_cnt", blk_cnt, 12);
        check("t3_i", i_out, (1 << 24) - 1);

        // k=1 with consumer stalled: second result dropped
        tick(2);
        rdy = 1'b0;
        log2n = 4'd1;
        push_exp(22, -22, 7, 1);
        send(10, -10, 3);
        send(12, -12, 4);
        send(20, -20, 5);
        send(22, -22, 6);
        tick(3);
        check("t4_keep_i", i_out, 11);
        check("t4_ovr", overrun, 1);
        check("t4_val", val_out, 1);
        check("t4_cnt", blk_cnt, 13);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("t4_clr", overrun, 0);
        rdy = 1'b1;
        tick(1);
        check("t4_val_fall", val_out, 0);

        // abort via en, then a block with log2n changed mid-way
        log2n = 4'd2;
        send(100, 0, 0);
        send(100, 0, 0);
        en = 1'b0;
        tick(1);
        en = 1'b1;
        tick(1);
        push_exp(32, -32, 32, 2);
        send(8, -8, 8);
        log2n = 4'd0;
        for (int n = 0; n < 3; n++) send(8, -8, 8);
        tick(3);
        check("t5_cnt", blk_cnt, 14);
        check("t5_i", i_out, 8);
        log2n = 4'd2;

        // asynchronous reset mid-block, then while a result is held
        send(5, 5, 5);
        send(5, 5, 5);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_i", i_out, 0);
        check("t6_rst_amp", a_out, 0);
        check("t6_rst_cnt", blk_cnt, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick(1);
        si = 0; sq = 0; sa = 0;
        for (int n = 0; n < 4; n++) begin
            si += 7 + n; sq -= 7 + n; sa += n + 1;
        end
        push_exp(si, sq, sa, 2);
        for (int n = 0; n < 4; n++) send(7 + n, -(7 + n), n + 1);
        tick(1);
        check("t6_val", val_out, 1);
        check("t6_cnt", blk_cnt, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst2_val", val_out, 0);
        check("t6_rst2_i", i_out, 0);
        check("t6_rst2_cnt", blk_cnt, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick(2);

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
